// File: rtl/igniter_ohm_meter.sv
// Multi-channel igniter continuity / resistance meter: test pulse, settle,
// averaged V/I sampling and a shared radix-4 restoring divide for R = V*SCALE/(I<<SHIFT).
module igniter_ohm_meter #(
  parameter int ADC_W       = 12,
  parameter int NCH         = 4,
  parameter int PULSE_CYC   = 96,
  parameter int SETTLE_CYC  = 256,
  parameter int AVG_LOG2    = 6,
  parameter int TIMEOUT_CYC = 4096,
  parameter int HOLDOFF_CYC = 65535,
  parameter int SCALE       = 42089,
  parameter int SHIFT       = 5,
  parameter int I_MIN       = 32,
  parameter int R_OUT_W     = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         ch_sel,
  input  logic               adc_valid,
  input  logic [ADC_W-1:0]   v_in,
  input  logic [ADC_W-1:0]   i_in,
  output logic [NCH-1:0]     pwm,
  output logic               busy,
  output logic               valid_out,
  output logic [3:0]         ch_out,
  output logic [R_OUT_W-1:0] r_out,
  output logic               open_out,
  output logic               sat_out,
  output logic               timeout_out
);

  localparam int SCALE_W = 16;
  localparam int MAG_W   = ADC_W - 1;
  localparam int SUM_W   = MAG_W + AVG_LOG2;
  localparam int NUM_W   = SUM_W + SCALE_W;
  localparam int NUM_WE  = NUM_W + (NUM_W % 2);
  localparam int DEN_W   = SUM_W + SHIFT;
  localparam int DEN_X   = DEN_W + 2;
  localparam int SCNT_W  = AVG_LOG2 + 1;
  localparam int STEPS   = NUM_WE / 2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RUN    = 3'd1;
  localparam logic [2:0] SAMPLE = 3'd2;
  localparam logic [2:0] DIV    = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  localparam logic [15:0]       PULSE_L    = 16'(PULSE_CYC);
  localparam logic [15:0]       SETTLE_M1  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0]       TIMEOUT_L  = 16'(TIMEOUT_CYC);
  localparam logic [15:0]       HOLDOFF_L  = 16'(HOLDOFF_CYC);
  localparam logic [4:0]        NCH_L      = 5'(NCH);
  localparam logic [SCNT_W-1:0] NSAMP_M1   = SCNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SUM_W-1:0]  IMIN_SUM   = SUM_W'(I_MIN << AVG_LOG2);
  localparam logic [7:0]        LAST_STEP  = 8'(STEPS - 1);

  // Negative (MSB set) readings clip to zero; positive codes are stored inverted.
  function automatic logic [MAG_W-1:0] mag_decode(input logic [ADC_W-1:0] code);
    if (code[ADC_W-1]) begin
      return '0;
    end else begin
      return code[MAG_W-1:0] ^ {MAG_W{1'b1}};
    end
  endfunction

  logic [2:0]         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [3:0]         ch_q, ch_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic [SUM_W-1:0]   vsum_q, vsum_d, isum_q, isum_d;
  logic [NUM_WE-1:0]  quo_q, quo_d;
  logic [DEN_W-1:0]   rem_q, rem_d;
  logic [DEN_X-1:0]   d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [7:0]         step_q, step_d;
  logic [NCH-1:0]     pwm_q, pwm_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [3:0]         ch_out_q, ch_out_d;
  logic [R_OUT_W-1:0] r_out_q, r_out_d;
  logic               open_q, open_d, sat_q, sat_d, timeout_q, timeout_d;

  logic [MAG_W-1:0]   vmag_s, imag_s;
  logic [SUM_W-1:0]   vsum_nx_s, isum_nx_s, den_base_s;
  logic [DEN_W-1:0]   den_s;
  logic [DEN_X-1:0]   rem_sh_s;
  logic [DEN_W-1:0]   rem_nx_s;
  logic [1:0]         qd_s;
  logic [NUM_WE-1:0]  quo_nx_s;
  logic               pwm_active_s;

  // Next-state, accumulation, divider step and result formatting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    scnt_d    = scnt_q;
    vsum_d    = vsum_q;
    isum_d    = isum_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    d3_d      = d3_q;
    step_d    = step_q;
    valid_d   = 1'b0;
    ch_out_d  = ch_out_q;
    r_out_d   = r_out_q;
    open_d    = open_q;
    sat_d     = sat_q;
    timeout_d = timeout_q;
    pwm_d     = '0;

    vmag_s     = mag_decode(v_in);
    imag_s     = mag_decode(i_in);
    vsum_nx_s  = vsum_q + SUM_W'(vmag_s);
    isum_nx_s  = isum_q + SUM_W'(imag_s);
    den_base_s = (isum_nx_s == '0) ? SUM_W'(1) : isum_nx_s;
    den_s      = DEN_W'(den_base_s) << SHIFT;

    // One radix-4 restoring step: pick the largest of 3d/2d/d that fits.
    rem_sh_s = {rem_q, quo_q[NUM_WE-1 -: 2]};
    if (rem_sh_s >= d3_q) begin
      qd_s     = 2'd3;
      rem_nx_s = rem_sh_s[DEN_W-1:0] - d3_q[DEN_W-1:0];
    end else if (rem_sh_s >= d2_q) begin
      qd_s     = 2'd2;
      rem_nx_s = rem_sh_s[DEN_W-1:0] - d2_q[DEN_W-1:0];
    end else if (rem_sh_s >= d1_q) begin
      qd_s     = 2'd1;
      rem_nx_s = rem_sh_s[DEN_W-1:0] - d1_q[DEN_W-1:0];
    end else begin
      qd_s     = 2'd0;
      rem_nx_s = rem_sh_s[DEN_W-1:0];
    end
    quo_nx_s = {quo_q[NUM_WE-3:0], qd_s};

    if ((state_q != IDLE) && (cnt_q != HOLDOFF_L)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (start && ({1'b0, ch_sel} < NCH_L)) begin
          state_d = RUN;
          ch_d    = ch_sel;
          cnt_d   = 16'd0;
          scnt_d  = '0;
          vsum_d  = '0;
          isum_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == SETTLE_M1) begin
          state_d = SAMPLE;
        end else begin
          state_d = RUN;
        end
      end
      SAMPLE: begin
        if (cnt_q == TIMEOUT_L) begin
          state_d   = HOLD;
          valid_d   = 1'b1;
          ch_out_d  = ch_q;
          timeout_d = 1'b1;
          open_d    = 1'b0;
          sat_d     = 1'b0;
          r_out_d   = '1;
        end else if (adc_valid) begin
          vsum_d = vsum_nx_s;
          isum_d = isum_nx_s;
          scnt_d = scnt_q + SCNT_W'(1);
          if (scnt_q == NSAMP_M1) begin
            // Load the dividend and the 1x/2x/3x divisor multiples once.
            state_d = DIV;
            quo_d   = NUM_WE'(vsum_nx_s) * NUM_WE'(SCALE);
            rem_d   = '0;
            d1_d    = DEN_X'(den_s);
            d2_d    = DEN_X'(den_s) << 1;
            d3_d    = DEN_X'(den_s) + (DEN_X'(den_s) << 1);
            step_d  = 8'd0;
          end else begin
            state_d = SAMPLE;
          end
        end else begin
          state_d = SAMPLE;
        end
      end
      DIV: begin
        quo_d  = quo_nx_s;
        rem_d  = rem_nx_s;
        step_d = step_q + 8'd1;
        if (step_q == LAST_STEP) begin
          state_d   = HOLD;
          valid_d   = 1'b1;
          ch_out_d  = ch_q;
          timeout_d = 1'b0;
          if (isum_q < IMIN_SUM) begin
            open_d  = 1'b1;
            sat_d   = 1'b0;
            r_out_d = '1;
          end else if (|quo_nx_s[NUM_WE-1:R_OUT_W]) begin
            open_d  = 1'b0;
            sat_d   = 1'b1;
            r_out_d = '1;
          end else begin
            open_d  = 1'b0;
            sat_d   = 1'b0;
            r_out_d = quo_nx_s[R_OUT_W-1:0];
          end
        end else begin
          state_d = DIV;
        end
      end
      HOLD: begin
        // A level start held past the holdoff must not retrigger.
        if ((cnt_q == HOLDOFF_L) && !start) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pwm_active_s = (state_d != IDLE) && (cnt_d < PULSE_L);
    for (int k = 0; k < NCH; k++) begin
      pwm_d[k] = pwm_active_s && (ch_d == 4'(k));
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      ch_q      <= 4'd0;
      scnt_q    <= '0;
      vsum_q    <= '0;
      isum_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      step_q    <= 8'd0;
      pwm_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ch_out_q  <= 4'd0;
      r_out_q   <= '0;
      open_q    <= 1'b0;
      sat_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      scnt_q    <= scnt_d;
      vsum_q    <= vsum_d;
      isum_q    <= isum_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      d3_q      <= d3_d;
      step_q    <= step_d;
      pwm_q     <= pwm_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ch_out_q  <= ch_out_d;
      r_out_q   <= r_out_d;
      open_q    <= open_d;
      sat_q     <= sat_d;
      timeout_q <= timeout_d;
    end
  end

  assign pwm         = pwm_q;
  assign busy        = busy_q;
  assign valid_out   = valid_q;
  assign ch_out      = ch_out_q;
  assign r_out       = r_out_q;
  assign open_out    = open_q;
  assign sat_out     = sat_q;
  assign timeout_out = timeout_q;

endmodule

// File: tb/tb_igniter_ohm_meter.sv
// Directed and randomized measurements of igniter_ohm_meter against an
// arithmetic reference model (sums, integer divide, flag rules).
module tb_igniter_ohm_meter;

  localparam int     HOLD_T  = 4500;
  localparam int     PULSE   = 96;
  localparam int     SETTLE  = 256;
  localparam int     TMO     = 4096;
  localparam int     NAVG    = 64;
  localparam int     DIV_CYC = 17;  // (11+6+16 bits rounded up to 34) / 2
  localparam longint SCALE   = 42089;
  localparam int     SHIFT   = 5;
  localparam int     I_MIN   = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ch_sel;
  logic        adc_valid;
  logic [11:0] v_in;
  logic [11:0] i_in;
  logic [3:0]  pwm;
  logic        busy;
  logic        valid_out;
  logic [3:0]  ch_out;
  logic [11:0] r_out;
  logic        open_out;
  logic        sat_out;
  logic        timeout_out;

  int checks = 0;
  int errors = 0;
  logic [11:0] last_r;
  logic        last_o, last_s, last_t;

  always #5 clk = ~clk;

  igniter_ohm_meter #(.HOLDOFF_CYC(HOLD_T)) dut (
    .clk(clk), .reset(reset), .start(start), .ch_sel(ch_sel),
    .adc_valid(adc_valid), .v_in(v_in), .i_in(i_in),
    .pwm(pwm), .busy(busy), .valid_out(valid_out), .ch_out(ch_out),
    .r_out(r_out), .open_out(open_out), .sat_out(sat_out), .timeout_out(timeout_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mag(input logic [11:0] code);
    return code[11] ? 0 : int'(code[10:0] ^ 11'h7FF);
  endfunction

  function automatic logic [11:0] enc(input int m);
    return {1'b0, 11'(m) ^ 11'h7FF};
  endfunction

  function automatic logic [11:0] rnd_code(input int base);
    int m;
    if ($urandom_range(0, 15) == 0) return {1'b1, 11'($urandom)};
    m = base + int'($urandom_range(0, 80)) - 40;
    if (m < 0) m = 0;
    if (m > 2047) m = 2047;
    return enc(m);
  endfunction

  // kind: 0 fixed codes, 1 random codes, 2 no adc_valid at all
  task automatic measure(input string name, input logic [3:0] ch, input int kind,
                         input logic [11:0] vc, input logic [11:0] ic,
                         input int restart_at, input int release_at);
    longint vs = 0, is = 0, q = 0;
    int nacc = 0, klast = -1, kvalid = -1, nvalid = 0, pwm_cnt = 0, pwm_bad = 0, kidle = -1;
    int vb, ib, exp_k, exp_idle;
    logic [3:0]  cap_ch = 4'd0, exp_pwm;
    logic [11:0] cap_r = 12'd0, exp_r, sv, si;
    logic cap_o = 1'b0, cap_s = 1'b0, cap_t = 1'b0, exp_o = 1'b0, exp_s = 1'b0, exp_t = 1'b0;
    vb = $urandom_range(10, 1900);
    ib = $urandom_range(20, 700);
    @(negedge clk);
    start = 1'b1;
    ch_sel = ch;
    for (int k = 0; k < HOLD_T + 1000 && kidle < 0; k++) begin
      @(negedge clk);
      start  = (k < release_at) || (k == restart_at);
      ch_sel = (k == restart_at) ? (ch ^ 4'd1) : ch;
      exp_pwm = (k < PULSE) ? 4'(1 << ch) : 4'd0;
      if (pwm !== exp_pwm) pwm_bad++;
      if (pwm !== 4'd0) pwm_cnt++;
      if (valid_out === 1'b1) begin
        nvalid++;
        if (kvalid < 0) begin
          kvalid = k; cap_ch = ch_out; cap_r = r_out;
          cap_o = open_out; cap_s = sat_out; cap_t = timeout_out;
        end
      end
      if (busy !== 1'b1 && kidle < 0) kidle = k;
      if (kind == 1) begin
        sv = rnd_code(vb); si = rnd_code(ib);
      end else begin
        sv = vc; si = ic;
      end
      adc_valid = (kind != 2) && (k % 4 == 0);
      v_in = sv;
      i_in = si;
      if (adc_valid && k >= SETTLE && nacc < NAVG) begin
        vs += mag(sv);
        is += mag(si);
        nacc++;
        if (nacc == NAVG) klast = k;
      end
    end
    adc_valid = 1'b0;
    start = 1'b0;

    if (nacc < NAVG) begin
      exp_t = 1'b1; exp_r = 12'hFFF; exp_k = TMO + 1;
    end else begin
      exp_k = klast + DIV_CYC + 1;
      if (is < I_MIN * NAVG) begin
        exp_o = 1'b1; exp_r = 12'hFFF;
      end else begin
        q = (vs * SCALE) / (((is == 0) ? 64'd1 : is) << SHIFT);
        if (q > 4095) begin
          exp_s = 1'b1; exp_r = 12'hFFF;
        end else begin
          exp_r = 12'(q);
        end
      end
    end
    exp_idle = ((release_at > HOLD_T) ? release_at : HOLD_T) + 1;

    chk({name, "_pwm_len"}, pwm_cnt, PULSE);
    chk({name, "_pwm_shape"}, pwm_bad, 0);
    chk({name, "_valid_cnt"}, nvalid, 1);
    chk({name, "_latency"}, kvalid, exp_k);
    chk({name, "_ch"}, 32'(cap_ch), 32'(ch));
    chk({name, "_r"}, 32'(cap_r), 32'(exp_r));
    chk({name, "_open"}, 32'(cap_o), 32'(exp_o));
    chk({name, "_sat"}, 32'(cap_s), 32'(exp_s));
    chk({name, "_tmo"}, 32'(cap_t), 32'(exp_t));
    chk({name, "_idle_at"}, kidle, exp_idle);
    @(negedge clk);
    chk({name, "_r_hold"}, 32'(r_out), 32'(exp_r));
    last_r = cap_r; last_o = cap_o; last_s = cap_s; last_t = cap_t;
  endtask

  task automatic abort_at(input string name, input int at_k);
    int nvalid = 0, nbusy = 0;
    @(negedge clk);
    start = 1'b1;
    ch_sel = 4'd1;
    for (int k = 0; k < at_k; k++) begin
      @(negedge clk);
      start = 1'b0;
      adc_valid = (k % 4 == 0);
      v_in = enc(500);
      i_in = enc(200);
      if (valid_out === 1'b1) nvalid++;
    end
    @(negedge clk);
    chk({name, "_pwm_before"}, 32'(pwm), (at_k < PULSE) ? 32'd2 : 32'd0);
    reset = 1'b1;
    adc_valid = 1'b0;
    @(negedge clk);
    chk({name, "_pwm_after"}, 32'(pwm), 32'd0);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_r_after"}, 32'(r_out), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      adc_valid = (k % 4 == 0);
      if (valid_out === 1'b1) nvalid++;
      if (busy !== 1'b0) nbusy++;
    end
    adc_valid = 1'b0;
    chk({name, "_no_valid"}, nvalid, 0);
    chk({name, "_stays_idle"}, nbusy, 0);
  endtask

  initial begin
    int nbusy;
    reset = 1'b1; start = 1'b0; ch_sel = 4'd0; adc_valid = 1'b0;
    v_in = 12'd0; i_in = 12'd0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_ch", 32'(ch_out), 32'd0);
    chk("rst_r", 32'(r_out), 32'd0);
    chk("rst_flags", 32'({open_out, sat_out, timeout_out}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    measure("normal", 4'd2, 0, 12'h79B, 12'h737, 1000, 0);
    chk("normal_r_const", 32'(last_r), 32'd657);
    measure("open", 4'd2, 0, 12'h79B, 12'h7F5, -1, 0);
    chk("open_flag_const", 32'(last_o), 32'd1);
    measure("sat", 4'd0, 0, 12'h02F, 12'h7D7, -1, 0);
    chk("sat_flag_const", 32'({last_s, last_r}), 32'h1FFF);
    measure("negv", 4'd1, 0, 12'h8A5, 12'h737, -1, 0);
    chk("negv_r_const", 32'(last_r), 32'd0);
    measure("negi", 4'd3, 0, 12'h79B, 12'hC12, -1, 0);
    chk("negi_open_const", 32'(last_o), 32'd1);

    nbusy = 0;
    @(negedge clk);
    start = 1'b1;
    ch_sel = 4'd5;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || pwm !== 4'd0) nbusy++;
    end
    start = 1'b0;
    chk("bad_ch_ignored", nbusy, 0);

    measure("tmo", 4'd0, 2, 12'd0, 12'd0, -1, 0);
    chk("tmo_flag_const", 32'(last_t), 32'd1);
    abort_at("abort_run", 50);
    abort_at("abort_sample", 300);
    measure("holdstart", 4'd3, 0, 12'h79B, 12'h737, -1, 4700);
    measure("rearm", 4'd1, 1, 12'd0, 12'd0, -1, 0);
    for (int n = 0; n < 4; n++) begin
      measure($sformatf("rand%0d", n), 4'($urandom_range(0, 3)), 1, 12'd0, 12'd0, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/igniter_ohm_meter.md
Name: igniter_ohm_meter

Overview:
- Parametrised multi-channel igniter continuity and resistance meter.
- On a start request it fires a test pulse on one selected channel, waits for the circuit to settle, then averages 2^AVG_LOG2 paired ADC voltage/current samples.
- It computes R = Vsum*SCALE / (Isum<<SHIFT) with a shared radix-4 restoring divider and reports a flagged resistance tagged with its channel.
- It sits between the ADC sample stream and the launch-controller status logic, and serves NCH igniters with one divider.

Parameters:
- ADC_W, 12: ADC word width. Bit ADC_W-1 set means negative; magnitude = low ADC_W-1 bits XOR all-ones.
- NCH, 4: number of igniter channels (1..16).
- PULSE_CYC, 96: test-pulse length in clk cycles.
- SETTLE_CYC, 256: cycles from pulse start to first accepted sample (> PULSE_CYC not required).
- AVG_LOG2, 6: log2 of the number of samples averaged (0..7).
- TIMEOUT_CYC, 4096: cycle count by which sampling must complete (> SETTLE_CYC).
- HOLDOFF_CYC, 65535: minimum start-to-start spacing, max 65535.
- SCALE, 42089: unit constant; SCALE_W=16 bits.
- SHIFT, 5: denominator pre-shift. Defaults give r_out LSB = 1/32 ohm.
- I_MIN, 32: minimum mean current magnitude (ADC dn) for a valid reading.
- R_OUT_W, 12: result width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  measurement request, level.
- ch_sel  in  4  channel for the request, sampled with start.
- adc_valid  in  1  v_in/i_in sample strobe.
- v_in  in  ADC_W  igniter voltage, ADC format.
- i_in  in  ADC_W  igniter current, ADC format.
- pwm  out  NCH  per-channel test-pulse drive.
- busy  out  1  high in any state other than IDLE.
- valid_out  out  1  one-cycle result strobe.
- ch_out  out  4  channel of the result.
- r_out  out  R_OUT_W  resistance, unsigned.
- open_out  out  1  mean current below I_MIN.
- sat_out  out  1  quotient exceeded R_OUT_W.
- timeout_out  out  1  samples not collected in time.

Behaviour:
- Reset: state IDLE, cnt 0, accumulators 0.
  - pwm, busy, valid_out, all flags = 0; r_out = 0; ch_out = 0.
  - A reset mid-measurement aborts the measurement: pwm drops on the reset edge and no valid_out is issued.
- Operand conversion:
  - Vmag = 0 if v_in MSB is set, else the decoded magnitude.
  - Imag = 0 if i_in MSB is set, else the decoded magnitude.
- State IDLE → RUN: on start=1 with ch_sel<NCH.
  - Latch ch and clear cnt and the sums.
  - start with ch_sel>=NCH is ignored.
  - start is ignored in every state except IDLE.
- cnt: 16-bit, increments each cycle outside IDLE and saturates at HOLDOFF_CYC.
- pwm[ch] = 1 while state != IDLE and cnt < PULSE_CYC. This is exactly PULSE_CYC cycles, starting the cycle after start is accepted. All other pwm bits stay 0.
- RUN → SAMPLE when cnt == SETTLE_CYC-1.
- SAMPLE:
  - Each adc_valid adds Vmag to Vsum and Imag to Isum; each sum is ADC_W-1+AVG_LOG2 bits.
  - After the 2^AVG_LOG2-th accepted sample → DIV.
  - If cnt reaches TIMEOUT_CYC first → HOLD. That cycle valid_out=1, timeout_out=1, r_out=all-ones, open/sat=0.
  - adc_valid is ignored outside SAMPLE.
- DIV:
  - Numerator = Vsum*SCALE, NUM_W = ADC_W-1+AVG_LOG2+SCALE_W, padded to an even width.
  - Denominator = max(Isum,1)<<SHIFT.
  - Radix-4 restoring division: candidates 1x/2x/3x precomputed on entry; 2 quotient bits per cycle, MSB first.
  - Latency is NUM_W_even/2 cycles, fixed and data-independent.
- Result, at the end of DIV: valid_out pulses for 1 cycle, ch_out=ch, then → HOLD. Flags are mutually exclusive.
  - If Isum < (I_MIN<<AVG_LOG2): open_out=1, r_out=all-ones.
  - Else if quotient > 2^R_OUT_W-1: sat_out=1, r_out=all-ones.
  - Else: r_out = quotient, flags 0.
- Output hold: r_out, ch_out and the flags hold until the next result.
- HOLD → IDLE when cnt == HOLDOFF_CYC and start == 0. If start is still high, stay in HOLD until it is released (a level start never retriggers).

Test Plan:
- Normal reading: ch_sel=2, start 1 cycle, adc_valid every 4 cycles, v_in=0x79B (100 dn), i_in=0x737 (200 dn).
  - Required: pwm=4'b0100 for exactly 96 cycles.
  - Required: valid_out once, ch_out=2, r_out=657, all flags 0.
- Open circuit: same stimulus with i_in=0x7F5 (10 dn).
  - Required: open_out=1, r_out=0xFFF, sat_out=0.
- Saturation: v_in=2000 dn, i_in=40 dn.
  - Required: quotient 65764 > 4095, so sat_out=1, r_out=0xFFF.
- Negative / clipped voltage: v_in=0x800|any, i_in=200 dn → r_out=0, flags 0. Separately, i_in MSB set → Imag=0 → open_out=1.
- Timeout and aborts:
  - No adc_valid after start → valid_out with timeout_out=1 at cnt=4096.
  - reset asserted during SAMPLE → pwm=0 and busy=0 next cycle, no valid_out.
- Holdoff and re-arm:
  - Second start pulse at cnt=1000 is ignored.
  - start held high across HOLDOFF_CYC keeps busy=1 until start falls.
  - A new start accepted after release begins a new pulse.
